fp_addsub_arbiter: RTL
======================

Name: fp_addsub_arbiter

Overview:
- Shares one combinational single-precision add/sub datapath (32-bit operands in, 32-bit result plus overflow flag out) among NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives the adder's operands from registers and waits ADDER_LAT cycles before capturing the adder's outputs.
- Returns the result on a single tagged response channel with backpressure.
- Sits between the compute clients and the shared fp adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, requester tag width; must satisfy 2**ID_W >= NREQ
- ADDER_LAT, 1, cycles the adder inputs are held stable before the outputs are captured (1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*32  operand A, requester i at bits [32*i+31:32*i]
- req_b  in  NREQ*32  operand B, same packing
- req_op  in  NREQ  0 = A+B, 1 = A-B
- adder_a  out  32  registered operand A to the shared adder
- adder_b  out  32  registered operand B to the shared adder; sign already adjusted for op
- adder_result  in  32  adder sum
- adder_ovf  in  1  adder overflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_result  out  32  captured adder_result
- rsp_ovf  out  1  captured adder_ovf
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, adder_a=0, adder_b=0, busy=0, cnt=0.
- Reset asserted mid-operation aborts the operation. The pending result is discarded and never presented.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant g = first requester with req_valid set, searching from rr_ptr upward with wrap at NREQ.
  - req_ready[g]=1 combinationally in the same cycle; no other bit is set.
  - On that edge: adder_a<=req_a[g]; adder_b<=req_b[g] with bit 31 XORed by req_op[g]; id<=g; rr_ptr<=(g+1) mod NREQ; cnt<=ADDER_LAT; go to WAIT.
  - With no request, stay in IDLE; req_ready=0.
- WAIT:
  - req_ready=0. cnt decrements each cycle.
  - In the cycle cnt==1: rsp_result<=adder_result, rsp_ovf<=adder_ovf, rsp_id<=id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_ovf stay stable.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
  - With rsp_ready=0, hold indefinitely. No new grants are issued.
- adder_a and adder_b hold their values from grant until the next grant. They are not cleared on return to IDLE.
- Latency, grant edge to rsp_valid: ADDER_LAT+1 cycles.
  - ADDER_LAT=1: handshake in cycle T, rsp_valid in T+2.
  - Best-case repeat rate: one op per ADDER_LAT+2 cycles (rsp_ready held high).
- Requesters must hold valid, operands and op stable until req_ready. The block does not check this.
- Requesters not granted see req_ready=0 and keep waiting.
- Fairness: a continuously requesting client waits at most NREQ-1 grants.
- rr_ptr advances only on a grant.
- Unused requester slots (index >= NREQ) do not exist. rr_ptr wraps from NREQ-1 to 0.
- The block performs no floating-point arithmetic. Subtraction is only a sign flip of B; NaN and inf are passed through untouched.

Optional Feature:
- Macro: FP_ARB_STATS_EN.
- Defined: adds output stat_ops[15:0] and output stat_ovf[15:0].
  - stat_ops counts completed response handshakes.
  - stat_ovf counts handshakes with rsp_ovf=1.
  - Both counters saturate at 0xFFFF and reset to 0 on rst.
- Not defined: both ports exist and are tied to 16'h0000; no counter flops are built.

Test Plan:
- Reset, then requester 0 sends a=0x3F800000, b=0x40000000, op=0 (ADDER_LAT=1) -> req_ready=0001 that cycle; adder_a=0x3F800000, adder_b=0x40000000 next cycle; rsp_valid two cycles after grant; rsp_id=0; rsp_result equals the bench adder model output (0x40400000).
- Requester 2, a=0x40400000, b=0x3F800000, op=1 -> adder_b=0xBF800000, rsp_id=2. Repeat with b=0xBF800000, op=1 -> adder_b=0x3F800000.
- All four requesters hold valid continuously after reset -> grant order 0,1,2,3,0,1; req_ready is never multi-hot.
- rsp_ready held 0 for 10 cycles while requester 1 waits -> rsp_valid, rsp_id and rsp_result are stable throughout; req_ready[1] stays 0; grant to 1 occurs in the cycle after the response handshake.
- Adder model forces adder_ovf=1 -> rsp_ovf=1. With FP_ARB_STATS_EN after 3 ops (1 with overflow): stat_ops=3, stat_ovf=1. Without the macro both read 0.
- rst pulsed during WAIT, ADDER_LAT=4 -> rsp_valid never asserts for the aborted op; busy=0 and rr_ptr=0 after reset; the next request from requester 3 is granted and completes normally.

Source files
------------

// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end that shares one combinational fp add/sub datapath among NREQ clients.
// Define FP_ARB_STATS_EN to build the saturating stat_ops/stat_ovf counters.

module fp_arb_lane #(
    parameter int ID_W = 2,
    parameter int IDX  = 0
) (
    input  logic            valid,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            at_or_above
);
    // Requests at or past the pointer win first; the rest only matter on wrap.
    assign at_or_above = valid && (ID_W'(IDX) >= rr_ptr);
endmodule

module fp_addsub_arbiter #(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int ADDER_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_op,
    output logic [31:0]        adder_a,
    output logic [31:0]        adder_b,
    input  logic [31:0]        adder_result,
    input  logic               adder_ovf,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_ovf,
    output logic               busy,
    output logic [15:0]        stat_ops,
    output logic [15:0]        stat_ovf
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr, grant_idx, id_q;
    logic [3:0]            cnt;
    logic [NREQ-1:0]       upper;
    logic [NREQ-1:0][31:0] a_vec, b_vec;
    logic                  grant_fire, capture, rsp_fire;

    assign a_vec = req_a;
    assign b_vec = req_b;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        fp_arb_lane #(.ID_W(ID_W), .IDX(i)) u_lane (
            .valid      (req_valid[i]),
            .rr_ptr     (rr_ptr),
            .at_or_above(upper[i])
        );
    end

    // Lowest index in the upper window, else lowest index overall (wrap).
    always_comb begin
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (|upper ? upper[i] : req_valid[i]) grant_idx = ID_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        grant_fire = 1'b0;
        capture    = 1'b0;
        rsp_fire   = 1'b0;
        case (state_q)
            IDLE: if (|req_valid) begin
                req_ready[grant_idx] = 1'b1;
                grant_fire           = 1'b1;
                state_d              = WAIT;
            end
            WAIT: if (cnt == 4'd1) begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_fire = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            id_q       <= '0;
            adder_a    <= '0;
            adder_b    <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                adder_a <= a_vec[grant_idx];
                // Subtraction is only a sign flip; the adder sees A + (-B).
                adder_b <= b_vec[grant_idx] ^ {req_op[grant_idx], 31'b0};
                id_q    <= grant_idx;
                rr_ptr  <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
                cnt     <= 4'(ADDER_LAT);
            end else if (state_q == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_result <= adder_result;
                rsp_ovf    <= adder_ovf;
                rsp_id     <= id_q;
            end
        end
    end

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (rsp_fire) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (rsp_ovf && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
        end
    end
`else
    assign stat_ops = 16'h0000;
    assign stat_ovf = 16'h0000;
`endif

endmodule
